// File: rtl/spi_master_flash_if.sv
// rtl/spi_master_flash_if.sv - Descriptor/result bus between the flash controller and the SPI master
interface spi_master_flash_if;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [23:0] address;
  logic [7:0]  command;
  logic [2:0]  commtype;
  logic [6:0]  ndata_bits;
  logic [9:0]  frame_struct;
  logic [3:0]  dummy_cycles;
  logic        validflag;
  logic        validflag_out;
  logic        tready;

  modport master (
    output data_in, address, command, commtype, ndata_bits, frame_struct, dummy_cycles, validflag,
    input  data_out, validflag_out, tready
  );

  modport slave (
    input  data_in, address, command, commtype, ndata_bits, frame_struct, dummy_cycles, validflag,
    output data_out, validflag_out, tready
  );
endinterface

// File: rtl/spi_master_flash.sv
// rtl/spi_master_flash.sv - Single-I/O SPI master for serial NOR flash, SCLK = clk/2
module spi_master_flash #(
  parameter bit CPOL = 1'b1,
  parameter bit CPHA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_flash_if.slave bus,
  output logic              ss,
  output logic              sclk,
  output logic              mosi_dq0,
  input  logic              miso_dq1
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA_WR,
    S_DATA_RD,
    S_END
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        half_q, half_d;
  logic        rd_pend_q, rd_pend_d;
  logic        ss_q, ss_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        tready_q, tready_d;
  logic        vfo_q, vfo_d;
  logic [31:0] dout_q, dout_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] wr_q, wr_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [23:0] addr_q, addr_d;
  logic [2:0]  type_q, type_d;
  logic [5:0]  nbits_q, nbits_d;
  logic [3:0]  dummy_q, dummy_d;
  logic [9:0]  frame_q, frame_d;

  logic [5:0]  nbits_clamped;
  logic [31:0] rx_shift;
  logic        cur_bit;
  logic        is_read, has_addr, has_dummy, has_wr, has_rd;
  state_t      after_cmd, after_addr, after_dummy, phase_after;

  // Multi-I/O framing is held with the descriptor but not decoded in 1-1-1 mode.
  logic unused_frame;
  assign unused_frame = ^frame_q;

  assign nbits_clamped = (bus.ndata_bits > 7'd32) ? 6'd32 : bus.ndata_bits[5:0];
  assign rx_shift      = {rx_q[30:0], miso_dq1};

  function automatic logic [4:0] first_idx(state_t s, logic [3:0] dummy, logic [5:0] nbits);
    logic [5:0] n_m1;
    n_m1 = nbits - 6'd1;
    case (s)
      S_ADDR:               return 5'd23;
      S_DUMMY:              return {1'b0, dummy} - 5'd1;
      S_DATA_WR, S_DATA_RD: return n_m1[4:0];
      default:              return 5'd0;
    endcase
  endfunction

  always_comb begin
    is_read     = (type_q == 3'b010) || (type_q == 3'b011);
    has_addr    = (type_q == 3'b010) || (type_q == 3'b100) || (type_q == 3'b101);
    has_dummy   = (type_q == 3'b010) && (dummy_q != 4'd0);
    has_wr      = ((type_q == 3'b001) || (type_q == 3'b100)) && (nbits_q != 6'd0);
    has_rd      = is_read && (nbits_q != 6'd0);
    after_dummy = has_wr ? S_DATA_WR : (has_rd ? S_DATA_RD : S_END);
    after_addr  = has_dummy ? S_DUMMY : after_dummy;
    after_cmd   = has_addr ? S_ADDR : after_addr;
    case (state_q)
      S_CMD:   phase_after = after_cmd;
      S_ADDR:  phase_after = after_addr;
      S_DUMMY: phase_after = after_dummy;
      default: phase_after = S_END;
    endcase
  end

  always_comb begin
    case (state_q)
      S_CMD:     cur_bit = cmd_q[cnt_q[2:0]];
      S_ADDR:    cur_bit = addr_q[cnt_q];
      S_DATA_WR: cur_bit = wr_q[31];
      default:   cur_bit = 1'b0;
    endcase
  end

  // half_q=0: the coming edge is a trailing/prepare edge; half_q=1: it is a leading edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    rd_pend_d = rd_pend_q;
    ss_d      = ss_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    tready_d  = tready_q;
    vfo_d     = 1'b0;
    dout_d    = dout_q;
    rx_d      = rx_q;
    wr_d      = wr_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    type_d    = type_q;
    nbits_d   = nbits_q;
    dummy_d   = dummy_q;
    frame_d   = frame_q;

    case (state_q)
      S_IDLE: begin
        if (bus.validflag && tready_q) begin
          cmd_d     = bus.command;
          addr_d    = bus.address;
          type_d    = bus.commtype;
          nbits_d   = nbits_clamped;
          dummy_d   = bus.dummy_cycles;
          frame_d   = bus.frame_struct;
          wr_d      = bus.data_in;
          rx_d      = 32'd0;
          cnt_d     = 5'd7;
          half_d    = 1'b0;
          rd_pend_d = 1'b0;
          state_d   = S_CMD;
        end
      end

      S_END: begin
        if (!half_q) begin
          sclk_d = CPOL;
          half_d = 1'b1;
          if (CPHA && rd_pend_q) rx_d = rx_shift;
        end else begin
          ss_d      = 1'b1;
          tready_d  = 1'b1;
          mosi_d    = 1'b0;
          half_d    = 1'b0;
          rd_pend_d = 1'b0;
          state_d   = S_IDLE;
          if (is_read) begin
            dout_d = rx_q;
            vfo_d  = 1'b1;
          end
        end
      end

      default: begin
        if (!half_q) begin
          sclk_d   = CPOL;
          ss_d     = 1'b0;
          tready_d = 1'b0;
          half_d   = 1'b1;
          if (CPHA && rd_pend_q) rx_d = rx_shift;
          if (!CPHA) mosi_d = cur_bit;
        end else begin
          sclk_d    = ~CPOL;
          half_d    = 1'b0;
          rd_pend_d = (state_q == S_DATA_RD);
          if (CPHA) mosi_d = cur_bit;
          else if (state_q == S_DATA_RD) rx_d = rx_shift;
          if (state_q == S_DATA_WR) wr_d = {wr_q[30:0], 1'b0};
          if (cnt_q == 5'd0) begin
            state_d = phase_after;
            cnt_d   = first_idx(phase_after, dummy_q, nbits_q);
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      half_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      ss_q      <= 1'b1;
      sclk_q    <= CPOL;
      mosi_q    <= 1'b0;
      tready_q  <= 1'b1;
      vfo_q     <= 1'b0;
      dout_q    <= 32'd0;
      rx_q      <= 32'd0;
      wr_q      <= 32'd0;
      cmd_q     <= 8'd0;
      addr_q    <= 24'd0;
      type_q    <= 3'd0;
      nbits_q   <= 6'd0;
      dummy_q   <= 4'd0;
      frame_q   <= 10'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      rd_pend_q <= rd_pend_d;
      ss_q      <= ss_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      tready_q  <= tready_d;
      vfo_q     <= vfo_d;
      dout_q    <= dout_d;
      rx_q      <= rx_d;
      wr_q      <= wr_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      type_q    <= type_d;
      nbits_q   <= nbits_d;
      dummy_q   <= dummy_d;
      frame_q   <= frame_d;
    end
  end

  assign ss                = ss_q;
  assign sclk              = sclk_q;
  assign mosi_dq0          = mosi_q;
  assign bus.data_out      = dout_q;
  assign bus.validflag_out = vfo_q;
  assign bus.tready        = tready_q;

endmodule

// File: tb/tb_spi_master_flash.sv
// tb/tb_spi_master_flash.sv - Directed bench for spi_master_flash in CPOL/CPHA 1/1 and 0/0
module tb_spi_master_flash;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_master_flash_if bus0();
  spi_master_flash_if bus1();

  logic        ss0, sclk0, mosi0, ss1, sclk1, mosi1;
  logic        miso = 1'b0;
  logic        vf0, vf1;
  logic [31:0] data_in_r;
  logic [23:0] address_r;
  logic [7:0]  command_r;
  logic [2:0]  commtype_r;
  logic [6:0]  ndata_r;
  logic [9:0]  frame_r;
  logic [3:0]  dummy_r;

  assign bus0.data_in = data_in_r;    assign bus1.data_in = data_in_r;
  assign bus0.address = address_r;    assign bus1.address = address_r;
  assign bus0.command = command_r;    assign bus1.command = command_r;
  assign bus0.commtype = commtype_r;  assign bus1.commtype = commtype_r;
  assign bus0.ndata_bits = ndata_r;   assign bus1.ndata_bits = ndata_r;
  assign bus0.frame_struct = frame_r; assign bus1.frame_struct = frame_r;
  assign bus0.dummy_cycles = dummy_r; assign bus1.dummy_cycles = dummy_r;
  assign bus0.validflag = vf0;        assign bus1.validflag = vf1;

  spi_master_flash #(.CPOL(1'b0), .CPHA(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave),
    .ss(ss0), .sclk(sclk0), .mosi_dq0(mosi0), .miso_dq1(miso)
  );

  spi_master_flash #(.CPOL(1'b1), .CPHA(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .ss(ss1), .sclk(sclk1), .mosi_dq0(mosi1), .miso_dq1(miso)
  );

  // sel picks which instance the flash model and checks look at; dut1 is mode 1/1, dut0 is 0/0.
  logic        sel;
  logic        ss_m, sclk_m, mosi_m, tready_m, vfo_m, cpol_m, cpha_m;
  logic [31:0] dout_m;
  assign ss_m     = sel ? ss1 : ss0;
  assign sclk_m   = sel ? sclk1 : sclk0;
  assign mosi_m   = sel ? mosi1 : mosi0;
  assign tready_m = sel ? bus1.tready : bus0.tready;
  assign vfo_m    = sel ? bus1.validflag_out : bus0.validflag_out;
  assign dout_m   = sel ? bus1.data_out : bus0.data_out;
  assign cpol_m   = sel;
  assign cpha_m   = sel;

  int           bitn = 0;
  logic [127:0] cap = '0;
  int           rd_start = 0;
  int           rd_len = 0;
  logic [31:0]  resp = '0;
  logic         ss_prev = 1'b1;
  logic         sclk_prev = 1'b1;

  function automatic logic resp_bit(int n);
    if (n >= rd_start && n < rd_start + rd_len) return resp[rd_len - 1 - (n - rd_start)];
    return 1'b0;
  endfunction

  always @(ss_m or sclk_m) begin
    if (ss_m !== ss_prev) begin
      ss_prev = ss_m;
      if (ss_m === 1'b0) begin
        bitn = 0;
        cap  = '0;
        miso = cpha_m ? 1'b0 : resp_bit(0);
      end
    end else if (ss_m === 1'b0 && sclk_m !== sclk_prev) begin
      if (sclk_m !== cpol_m) begin
        if (cpha_m) miso = resp_bit(bitn);
        else        cap  = {cap[126:0], mosi_m};
      end else begin
        if (cpha_m) cap  = {cap[126:0], mosi_m};
        else        miso = resp_bit(bitn + 1);
        bitn++;
      end
    end
    sclk_prev = sclk_m;
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_valid();
    if (sel) vf1 = 1'b1;
    else     vf0 = 1'b1;
    @(negedge clk);
    vf0 = 1'b0;
    vf1 = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int ss_low, output int vfo_early, output bit done);
    ss_low = 0;
    vfo_early = 0;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (ss_m === 1'b0) ss_low++;
      if (tready_m === 1'b1 && ss_m === 1'b1) done = 1'b1;
      else if (vfo_m === 1'b1) vfo_early++;
    end
  endtask

  task automatic run_txn(input string name, input int nb, input logic exp_vfo,
                         input logic [127:0] exp_cap, input logic [31:0] exp_dout);
    int ss_low, vfo_early;
    bit done;
    pulse_valid();
    chk({name, "/ready_before_start"}, 128'(tready_m), 128'(1));
    chk({name, "/prev_vfo_single"}, 128'(vfo_m), 128'(0));
    wait_done(4 * nb + 20, ss_low, vfo_early, done);
    chk({name, "/done"}, 128'(done), 128'(1));
    chk({name, "/ss_low_cycles"}, 128'(ss_low), 128'(2 * nb + 1));
    chk({name, "/vfo_early"}, 128'(vfo_early), 128'(0));
    chk({name, "/vfo_at_end"}, 128'(vfo_m), 128'(exp_vfo));
    chk({name, "/data_out"}, 128'(dout_m), 128'(exp_dout));
    chk({name, "/sclk_cycles"}, 128'(bitn), 128'(nb));
    chk({name, "/mosi_bits"}, cap, exp_cap);
  endtask

  task automatic set_desc(input logic [2:0] t, input logic [7:0] c, input logic [23:0] a,
                          input logic [3:0] d, input logic [6:0] n, input logic [31:0] din);
    commtype_r = t;
    command_r  = c;
    address_r  = a;
    dummy_r    = d;
    ndata_r    = n;
    data_in_r  = din;
  endtask

  initial begin
    int bad;
    int ss_low, vfo_early;
    bit done;
    sel = 1'b1;
    rst = 1'b0;
    vf0 = 1'b0;
    vf1 = 1'b0;
    frame_r = 10'd0;
    set_desc(3'b000, 8'h00, 24'h0, 4'd0, 7'd0, 32'h0);
    repeat (3) @(negedge clk);

    chk("reset/ss", 128'(ss1), 128'(1));
    chk("reset/sclk_cpol1", 128'(sclk1), 128'(1));
    chk("reset/sclk_cpol0", 128'(sclk0), 128'(0));
    chk("reset/mosi", 128'(mosi1), 128'(0));
    chk("reset/data_out", 128'(bus1.data_out), 128'(0));
    chk("reset/vfo", 128'(bus1.validflag_out), 128'(0));
    chk("reset/tready", 128'(bus1.tready), 128'(1));

    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ss1 !== 1'b1 || sclk1 !== 1'b1 || mosi1 !== 1'b0 || bus1.tready !== 1'b1) bad++;
    end
    chk("idle/stable", 128'(bad), 128'(0));

    set_desc(3'b010, 8'h5A, 24'h555555, 4'd8, 7'd32, 32'h0);
    resp = 32'hA0A0A0A3; rd_start = 40; rd_len = 32;
    run_txn("read_dummy", 72, 1'b1, 128'({8'h5A, 24'h555555, 40'h0}), 32'hA0A0A0A3);

    set_desc(3'b010, 8'hA3, 24'h555555, 4'd0, 7'd8, 32'h0);
    frame_r = 10'h004;
    resp = 32'h000000A3; rd_start = 32; rd_len = 8;
    run_txn("read_b2b", 40, 1'b1, 128'({8'hA3, 24'h555555, 8'h00}), 32'h000000A3);

    frame_r = 10'd0;
    set_desc(3'b001, 8'h06, 24'h0, 4'd0, 7'd8, 32'h5A000000);
    rd_len = 0;
    run_txn("write", 16, 1'b0, 128'(16'h065A), 32'h000000A3);

    set_desc(3'b001, 8'h02, 24'h0, 4'd0, 7'd40, 32'h12345678);
    run_txn("write_clamp", 40, 1'b0, 128'({8'h02, 32'h12345678}), 32'h000000A3);

    set_desc(3'b100, 8'h20, 24'h0ABCDE, 4'd3, 7'd0, 32'hFFFFFFFF);
    run_txn("addr_no_data", 32, 1'b0, 128'({8'h20, 24'h0ABCDE}), 32'h000000A3);

    set_desc(3'b000, 8'h05, 24'h123456, 4'd0, 7'd8, 32'hFFFFFFFF);
    pulse_valid();
    repeat (4) @(negedge clk);
    chk("busy/tready_low", 128'(tready_m), 128'(0));
    set_desc(3'b001, 8'hFF, 24'h0, 4'd0, 7'd32, 32'hFFFFFFFF);
    pulse_valid();
    wait_done(60, ss_low, vfo_early, done);
    chk("busy/done", 128'(done), 128'(1));
    chk("busy/sclk_cycles", 128'(bitn), 128'(8));
    chk("busy/mosi_bits", cap, 128'(8'h05));
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ss_m !== 1'b1 || tready_m !== 1'b1) bad++;
    end
    chk("busy/ignored_no_restart", 128'(bad), 128'(0));

    set_desc(3'b110, 8'hC7, 24'hFFFFFF, 4'd5, 7'd16, 32'hFFFFFFFF);
    run_txn("type110_cmd_only", 8, 1'b0, 128'(8'hC7), 32'h000000A3);

    sel = 1'b0;
    @(negedge clk);
    chk("mode0/idle_sclk", 128'(sclk_m), 128'(0));
    set_desc(3'b010, 8'h5A, 24'h555555, 4'd8, 7'd32, 32'h0);
    resp = 32'hA0A0A0A3; rd_start = 40; rd_len = 32;
    run_txn("mode0_read", 72, 1'b1, 128'({8'h5A, 24'h555555, 40'h0}), 32'hA0A0A0A3);

    sel = 1'b1;
    @(negedge clk);
    pulse_valid();
    repeat (30) @(negedge clk);
    chk("midreset/in_progress", 128'(ss_m), 128'(0));
    rst = 1'b0;
    #1;
    chk("midreset/ss", 128'(ss1), 128'(1));
    chk("midreset/sclk", 128'(sclk1), 128'(1));
    chk("midreset/tready", 128'(bus1.tready), 128'(1));
    chk("midreset/mosi", 128'(mosi1), 128'(0));
    chk("midreset/data_out", 128'(bus1.data_out), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    set_desc(3'b001, 8'h06, 24'h0, 4'd0, 7'd8, 32'h5A000000);
    rd_len = 0;
    run_txn("after_reset_write", 16, 1'b0, 128'(16'h065A), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
